// File: rtl/cmd_fetch_queue.sv
// Instruction prefetch queue between ROM fetch and execute, owning the jump/flush path.
// Optional feature: define CMD_FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass.
module cmd_fetch_queue #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_wr_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pause_read,
    output logic [ADDR_W-1:0] jmp_addr,
    output logic [DATA_W-1:0] cmd_out,
    output logic [ADDR_W-1:0] cmd_addr_out,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] NO_JMP    = '1;
    localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  PAUSE_LVL = CNT_W'(DEPTH - 2);

    typedef enum logic {
        ST_RUN,
        ST_JUMP_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_jmp_addr;
    logic              r_overflow;

    logic w_jmp_valid;
    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_flush;
    logic w_jmp_load;
    logic w_jmp_clear;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_jmp_valid = jmp_req && (jmp_target != NO_JMP);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_LVL);

`ifdef CMD_FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && (r_state == ST_RUN) && cmd_wr && !jmp_req;
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In JUMP_WAIT the first write strobe proves fetch has sampled jmp_addr; that word is wrong-path.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_jmp_load  = 1'b0;
        w_jmp_clear = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_jmp_valid) begin
                    w_flush     = 1'b1;
                    w_jmp_load  = 1'b1;
                    w_state_nxt = ST_JUMP_WAIT;
                end else if (cmd_wr) begin
                    w_accept = 1'b1;
                end
            end
            ST_JUMP_WAIT: begin
                if (w_jmp_valid) begin
                    w_flush    = 1'b1;
                    w_jmp_load = 1'b1;
                end else if (cmd_wr) begin
                    w_jmp_clear = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // A bypassed word taken by execute in the same cycle never enters storage.
    assign w_pop  = !w_empty && cmd_ready;
    assign w_push = w_accept && !w_full && !(w_bypass && cmd_ready);
    assign w_drop = w_accept && w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_jmp_addr <= NO_JMP;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_mem_data[r_wr_ptr] <= rom_data;
                    r_mem_addr[r_wr_ptr] <= cmd_wr_addr;
                    r_wr_ptr             <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            if (w_jmp_load) begin
                r_jmp_addr <= jmp_target;
            end else if (w_jmp_clear) begin
                r_jmp_addr <= NO_JMP;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Registered count leaves two slots of slack for fetch's registered strobe.
    assign pause_read   = (r_count >= PAUSE_LVL);
    assign jmp_addr     = r_jmp_addr;
    assign overflow     = r_overflow;
    assign cmd_valid    = !w_empty || w_bypass;
    assign cmd_out      = w_bypass ? rom_data    : r_mem_data[r_rd_ptr];
    assign cmd_addr_out = w_bypass ? cmd_wr_addr : r_mem_addr[r_rd_ptr];

endmodule

// File: tb/tb_cmd_fetch_queue.sv
// Directed self-checking bench for cmd_fetch_queue (DEPTH=4, ADDR_W=12, DATA_W=14).
module tb_cmd_fetch_queue;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_wr_addr;
    logic [DATA_W-1:0] rom_data;
    logic              pause_read;
    logic [ADDR_W-1:0] jmp_addr;
    logic [DATA_W-1:0] cmd_out;
    logic [ADDR_W-1:0] cmd_addr_out;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              jmp_req;
    logic [ADDR_W-1:0] jmp_target;
    logic              overflow;

    int n_checks;
    int n_errors;

    cmd_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_wr      (cmd_wr),
        .cmd_wr_addr (cmd_wr_addr),
        .rom_data    (rom_data),
        .pause_read  (pause_read),
        .jmp_addr    (jmp_addr),
        .cmd_out     (cmd_out),
        .cmd_addr_out(cmd_addr_out),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_wr    = 1'b0;
        jmp_req   = 1'b0;
        cmd_ready = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_wr      = 1'b1;
        cmd_wr_addr = a;
        rom_data    = d;
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check({tag, "_vld"}, 32'(cmd_valid), 32'd1);
        check({tag, "_addr"}, 32'(cmd_addr_out), 32'(a));
        check({tag, "_data"}, 32'(cmd_out), 32'(d));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        cmd_wr_addr = '0;
        rom_data    = '0;
        jmp_target  = '0;
        idle();

        // reset state
        tick();
        tick();
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_pause", 32'(pause_read), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_jmp", 32'(jmp_addr), 32'hFFF);
        check("rst_out", 32'(cmd_out), 32'd0);
        check("rst_aout", 32'(cmd_addr_out), 32'd0);
        reset = 1'b1;
        tick();

        // ordered push / pause threshold / ordered pop
        push(12'h000, 14'h100);
        check("p1_valid", 32'(cmd_valid), 32'd1);
        check("p1_pause", 32'(pause_read), 32'd0);
        push(12'h001, 14'h101);
        check("p2_pause", 32'(pause_read), 32'd1);
        push(12'h002, 14'h102);
        check("p3_pause", 32'(pause_read), 32'd1);
        pop_expect("pop0", 12'h000, 14'h100);
        pop_expect("pop1", 12'h001, 14'h101);
        check("pop1_pause", 32'(pause_read), 32'd0);
        // simultaneous push and pop with one entry queued
        cmd_wr      = 1'b1;
        cmd_wr_addr = 12'h003;
        rom_data    = 14'h103;
        cmd_ready   = 1'b1;
        tick();
        idle();
        pop_expect("pp_head", 12'h003, 14'h103);
        check("pp_empty", 32'(cmd_valid), 32'd0);

        // overflow: five writes into a four-entry queue
        for (int i = 0; i < 5; i++) begin
            cmd_wr      = 1'b1;
            cmd_wr_addr = ADDR_W'(12'h020 + i);
            rom_data    = DATA_W'(14'h200 + i);
            tick();
            if (i == 3) check("ovf_before", 32'(overflow), 32'd0);
        end
        idle();
        check("ovf_set", 32'(overflow), 32'd1);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            pop_expect("ovf_pop", ADDR_W'(12'h020 + i), DATA_W'(14'h200 + i));
        end
        check("ovf_drained", 32'(cmd_valid), 32'd0);
        check("ovf_keep", 32'(overflow), 32'd1);

        // asynchronous reset mid-stream with 3 words queued
        push(12'h030, 14'h030);
        push(12'h031, 14'h031);
        push(12'h032, 14'h032);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid), 32'd0);
        check("arst_jmp", 32'(jmp_addr), 32'hFFF);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_pause", 32'(pause_read), 32'd0);
        tick();
        reset = 1'b1;
        push(12'h050, 14'h050);
        check("arst_pause2", 32'(pause_read), 32'd0);
        pop_expect("arst_pop", 12'h050, 14'h050);
        check("arst_empty", 32'(cmd_valid), 32'd0);

        // jump flushes queue, first post-jump word discarded
        push(12'h060, 14'h060);
        push(12'h061, 14'h061);
        push(12'h062, 14'h062);
        jmp_req    = 1'b1;
        jmp_target = 12'h040;
        tick();
        jmp_req = 1'b0;
        check("jmp_valid", 32'(cmd_valid), 32'd0);
        check("jmp_addr", 32'(jmp_addr), 32'h040);
        check("jmp_pause", 32'(pause_read), 32'd0);
        tick();
        check("jmp_hold", 32'(jmp_addr), 32'h040);
        push(12'h063, 14'h063);
        check("jmp_discard", 32'(cmd_valid), 32'd0);
        check("jmp_clear", 32'(jmp_addr), 32'hFFF);
        push(12'h040, 14'h2AA);
        pop_expect("jmp_tgt", 12'h040, 14'h2AA);

        // all-ones target is ignored
        push(12'h070, 14'h070);
        push(12'h071, 14'h071);
        jmp_req    = 1'b1;
        jmp_target = 12'hFFF;
        tick();
        jmp_req = 1'b0;
        check("nj_jmp", 32'(jmp_addr), 32'hFFF);
        push(12'h072, 14'h072);
        check("nj_pause", 32'(pause_read), 32'd1);
        pop_expect("nj_pop0", 12'h070, 14'h070);
        pop_expect("nj_pop1", 12'h071, 14'h071);
        pop_expect("nj_pop2", 12'h072, 14'h072);

        // jump with push in RUN, then re-jump with write in JUMP_WAIT
        push(12'h0A0, 14'h0A0);
        cmd_wr      = 1'b1;
        cmd_wr_addr = 12'h0A1;
        jmp_req     = 1'b1;
        jmp_target  = 12'h080;
        tick();
        check("jp_valid", 32'(cmd_valid), 32'd0);
        check("jp_addr", 32'(jmp_addr), 32'h080);
        jmp_target = 12'h090;
        tick();
        jmp_req = 1'b0;
        check("jw_addr", 32'(jmp_addr), 32'h090);
        check("jw_valid", 32'(cmd_valid), 32'd0);
        tick();
        cmd_wr = 1'b0;
        check("jw_clear", 32'(jmp_addr), 32'hFFF);
        check("jw_valid2", 32'(cmd_valid), 32'd0);

        // empty-queue write with execute ready
        cmd_wr      = 1'b1;
        cmd_wr_addr = 12'h010;
        rom_data    = 14'h155;
        cmd_ready   = 1'b1;
        #1;
`ifdef CMD_FETCH_QUEUE_BYPASS_EN
        check("byp_valid", 32'(cmd_valid), 32'd1);
        check("byp_addr", 32'(cmd_addr_out), 32'h010);
        check("byp_data", 32'(cmd_out), 32'h155);
        tick();
        cmd_wr = 1'b0;
        check("byp_notstored", 32'(cmd_valid), 32'd0);
`else
        check("lat_valid0", 32'(cmd_valid), 32'd0);
        tick();
        cmd_wr = 1'b0;
        check("lat_valid1", 32'(cmd_valid), 32'd1);
        check("lat_addr", 32'(cmd_addr_out), 32'h010);
        tick();
        check("lat_popped", 32'(cmd_valid), 32'd0);
`endif
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cmd_fetch_queue.md
# cmd_fetch_queue

Instruction prefetch queue sitting directly downstream of the ROM fetch stage and upstream of the execute/decode stage. Each cycle the fetch stage asserts its command-write strobe, the queue captures the ROM word and its address. It presents the oldest word to execute over a valid/ready handshake and throttles fetch through `pause_read`. It also owns the jump path: it drives `jmp_addr` back to fetch, flushes stale words, and discards wrong-path words until fetch has taken the jump.

## Interface
- `DATA_W`, 14, command word width
- `ADDR_W`, 12, instruction address width; all-ones is reserved as "no jump"
- `DEPTH`, 4, queue entries; power of two, ≥4

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_wr`  in  1  fetch command-write strobe; one new word per high cycle
- `cmd_wr_addr`  in  ADDR_W  address of the word being written
- `rom_data`  in  DATA_W  ROM word, valid in the same cycle as `cmd_wr`
- `pause_read`  out  1  throttle to fetch
- `jmp_addr`  out  ADDR_W  jump target to fetch; all-ones = no jump
- `cmd_out`  out  DATA_W  oldest queued word
- `cmd_addr_out`  out  ADDR_W  address of `cmd_out`
- `cmd_valid`  out  1  `cmd_out` is valid
- `cmd_ready`  in  1  execute accepts `cmd_out`
- `jmp_req`  in  1  execute requests a jump, one-cycle pulse
- `jmp_target`  in  ADDR_W  target address for `jmp_req`
- `overflow`  out  1  sticky flag: a write was dropped because the queue was full

## Operation
- Storage: circular buffer of {addr, word}. Read and write pointers are log2(DEPTH) bits and wrap naturally. `count` is log2(DEPTH)+1 bits.
- Push: `cmd_wr`=1, not discarding, and `count`<DEPTH.
  - If `cmd_wr`=1 while `count`==DEPTH, the word is dropped and `overflow` is set. Only reset clears `overflow`.
- Pop: `cmd_valid`=1 and `cmd_ready`=1.
  - A push and a pop in the same cycle leave `count` unchanged.
- `cmd_valid` = (`count`≠0). `cmd_out` and `cmd_addr_out` come from the entry at the read pointer.
- `pause_read` = (`count` ≥ DEPTH−2). It is driven from the registered count, which leaves two slots of slack for fetch's registered strobe.
- State machine, states RUN and JUMP_WAIT:
  - RUN: normal push and pop.
    - On `jmp_req` with `jmp_target`≠all-ones: flush (pointers and `count` set to 0), register `jmp_addr`←`jmp_target`, go to JUMP_WAIT.
    - A `jmp_req` with an all-ones target is ignored.
  - JUMP_WAIT: `cmd_wr` words are discarded (not stored, no overflow).
    - On the first cycle with `cmd_wr`=1, fetch has sampled `jmp_addr`. Set `jmp_addr`←all-ones and return to RUN.
    - A new valid `jmp_req` in JUMP_WAIT flushes again and replaces `jmp_addr`, staying in JUMP_WAIT.
- Simultaneous events:
  - `jmp_req` together with a pop: the pop completes, then the flush applies.
  - `jmp_req` together with a push in RUN: the flush wins and the word is discarded.
  - `jmp_req` together with `cmd_wr` in JUMP_WAIT: the new target is latched and the state stays JUMP_WAIT.
- Reset asserted mid-operation clears everything immediately, regardless of the clock.

## Timing
- Reset values:
  - `cmd_valid`=0, `pause_read`=0, `overflow`=0
  - `jmp_addr`=all-ones
  - `cmd_out`=0, `cmd_addr_out`=0 (memory cleared)
  - state RUN
- Write-to-valid latency: 1 cycle. A word pushed at edge N appears with `cmd_valid`=1 after edge N.
- Pop: an accepted word is replaced by the next entry after the same edge.
- `jmp_req` sampled at edge N:
  - `cmd_valid`=0 and `jmp_addr`=target after edge N.
  - `jmp_addr` returns to all-ones after the first edge at which `cmd_wr`=1.
- Throughput: one push and one pop per cycle.

## Configuration
- `CMD_FETCH_QUEUE_BYPASS_EN` defined:
  - When `count`==0, state is RUN, `cmd_wr`=1 and `jmp_req`=0, the incoming word is presented combinationally on `cmd_out`/`cmd_addr_out` with `cmd_valid`=1 (0-cycle latency).
  - If `cmd_ready`=1 in that cycle, the word is consumed and not stored.
- Undefined: no bypass; latency is always 1 cycle as above.

## Test plan
- Reset low mid-stream with 3 words queued -> immediately `cmd_valid`=0, `jmp_addr`=12'hFFF, `overflow`=0; after release, pushes resume from an empty queue.
- Push addresses 0,1,2 with `cmd_ready`=0 (DEPTH=4) -> `pause_read`=1 once `count`=2; popping returns 0,1,2 in order with matching `cmd_addr_out`.
- 5 consecutive `cmd_wr` with `cmd_ready`=0 -> 4 stored, 5th dropped, `overflow`=1 and it stays 1.
- `jmp_req` with `jmp_target`=12'h040 while 3 words are queued -> next cycle `cmd_valid`=0 and `jmp_addr`=12'h040; the first following `cmd_wr` word is discarded and `jmp_addr`=12'hFFF afterwards; the next word, at 12'h040, is queued.
- `jmp_req` with `jmp_target`=12'hFFF -> ignored: queue contents intact, state stays RUN.
- With the bypass macro defined, empty queue, `cmd_wr`=1 with addr 12'h010 and `cmd_ready`=1 -> `cmd_valid`=1 and `cmd_addr_out`=12'h010 in the same cycle, `count` stays 0. Without the macro -> `cmd_valid` rises one cycle later.
